// File: rtl/miner_pkg.sv
// Shared constants and state encodings for the miner host front end.
package miner_pkg;

  localparam int FRAME_LEN    = 76;
  localparam int RESULT_BYTES = 5;

  localparam logic [7:0] C_SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] C_ST_SOLVED    = 8'h01;
  localparam logic [7:0] C_ST_EXHAUSTED = 8'h02;
  localparam logic [7:0] C_ST_BAD_CSUM  = 8'hEE;

  typedef enum logic [2:0] {
    SOLVER_WORKING    = 3'd0,
    SOLVER_TRANSITION = 3'd1,
    SOLVER_FOUND      = 3'd2,
    SOLVER_NONE       = 3'd3
  } solver_state_t;

  typedef enum logic [2:0] {
    D_IDLE   = 3'd0,
    D_RECV   = 3'd1,
    D_CHECK  = 3'd2,
    D_RUN    = 3'd3,
    D_REPORT = 3'd4,
    D_NACK   = 3'd5
  } disp_state_t;

endpackage

// File: rtl/byte_serializer.sv
// Parallel-in, valid/ready byte-out shifter; sends i_len bytes MSB first.
module byte_serializer #(
  parameter int NBYTES = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic [2:0]            i_len,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0] r_buf;
  logic [7:0]   r_data;
  logic         r_valid;
  logic [2:0]   r_left;

  // r_left counts bytes still queued behind the one on o_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_left  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data[W-1 -: 8];
      r_buf   <= {i_data[W-9:0], 8'h00};
      r_left  <= i_len - 3'd1;
    end else if (r_valid && i_ready) begin
      if (r_left == 3'd0) begin
        r_valid <= 1'b0;
      end else begin
        r_data <= r_buf[W-1 -: 8];
        r_buf  <= {r_buf[W-9:0], 8'h00};
        r_left <= r_left - 3'd1;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_valid && i_ready && (r_left == 3'd0);

endmodule

// File: rtl/work_dispatcher.sv
// Receives a work frame from the host, runs block_solver on it and reports the result.
module work_dispatcher
  import miner_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = C_SYNC_BYTE,
  parameter logic [7:0] ST_SOLVED    = C_ST_SOLVED,
  parameter logic [7:0] ST_EXHAUSTED = C_ST_EXHAUSTED,
  parameter logic [7:0] ST_BAD_CSUM  = C_ST_BAD_CSUM
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] midstate,
  output logic [95:0]  header_leftovers,
  output logic [255:0] target,
  output logic         solver_rst_n,
  input  logic [2:0]   solver_state,
  input  logic [31:0]  solver_nonce,
  output logic         busy
);

  disp_state_t r_state, w_state_nxt;
  logic [607:0] r_sr;
  logic [6:0]   r_count;
  logic [7:0]   r_csum;
  logic [7:0]   r_csum_rx;
  logic         r_solver_rst_n;
  logic         r_busy;

  logic         w_in_ready;
  logic         w_hs;
  logic         w_sync;
  logic         w_clr;
  logic         w_shift;
  logic         w_cap;
  logic         w_load;
  logic [39:0]  w_load_data;
  logic [2:0]   w_load_len;
  logic         w_rst_nxt;
  logic         w_busy_nxt;
  logic         w_ser_last;

  // A finished solver result blocks the input so a coincident abort byte stays pending.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      D_IDLE, D_RECV: w_in_ready = 1'b1;
      D_RUN:          w_in_ready = (solver_state < 3'd2);
      default:        w_in_ready = 1'b0;
    endcase
  end

  assign w_hs   = in_valid && w_in_ready;
  assign w_sync = w_hs && (in_data == SYNC_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_cap       = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_len  = 3'd0;
    w_rst_nxt   = r_solver_rst_n;
    w_busy_nxt  = r_busy;
    case (r_state)
      D_IDLE: begin
        w_rst_nxt = 1'b0;
        if (w_sync) begin
          w_clr       = 1'b1;
          w_state_nxt = D_RECV;
        end
      end
      D_RECV: begin
        if (w_hs) begin
          if (r_count == 7'(FRAME_LEN)) begin
            w_cap       = 1'b1;
            w_state_nxt = D_CHECK;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      D_CHECK: begin
        if (r_csum == r_csum_rx) begin
          w_rst_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = D_RUN;
        end else begin
          w_load      = 1'b1;
          w_load_data = {ST_BAD_CSUM, 32'h0};
          w_load_len  = 3'd1;
          w_state_nxt = D_NACK;
        end
      end
      D_RUN: begin
        if (solver_state == SOLVER_FOUND || solver_state == SOLVER_NONE) begin
          w_load      = 1'b1;
          w_load_data = {(solver_state == SOLVER_FOUND) ? ST_SOLVED : ST_EXHAUSTED,
                         solver_nonce};
          w_load_len  = 3'(RESULT_BYTES);
          w_rst_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = D_REPORT;
        end else if (w_sync) begin
          w_clr       = 1'b1;
          w_rst_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = D_RECV;
        end
      end
      D_REPORT, D_NACK: begin
        w_rst_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        if (w_ser_last) begin
          w_state_nxt = D_IDLE;
        end
      end
      default: begin
        w_rst_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = D_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= D_IDLE;
      r_sr           <= '0;
      r_count        <= '0;
      r_csum         <= '0;
      r_csum_rx      <= '0;
      r_solver_rst_n <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_solver_rst_n <= w_rst_nxt;
      r_busy         <= w_busy_nxt;
      if (w_clr) begin
        r_count <= '0;
        r_csum  <= '0;
      end else if (w_shift) begin
        r_sr    <= {r_sr[599:0], in_data};
        r_csum  <= r_csum ^ in_data;
        r_count <= r_count + 7'd1;
      end
      if (w_cap) begin
        r_csum_rx <= in_data;
      end
    end
  end

  byte_serializer #(.NBYTES(RESULT_BYTES)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_len   (w_load_len),
    .o_data  (out_data),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_last  (w_ser_last)
  );

  assign in_ready         = w_in_ready;
  assign midstate         = r_sr[607:352];
  assign header_leftovers = r_sr[351:256];
  assign target           = r_sr[255:0];
  assign solver_rst_n     = r_solver_rst_n;
  assign busy             = r_busy;

endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized scoreboard bench for work_dispatcher with a frame-level reference model.
module tb_work_dispatcher;

  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] midstate;
  logic [95:0]  header_leftovers;
  logic [255:0] target;
  logic         solver_rst_n;
  logic [2:0]   solver_state;
  logic [31:0]  solver_nonce;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[76];
  int or_mode = 0;
  int or_idx = 0;
  logic stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic watch_rst = 1'b0;
  logic rst_rose = 1'b0;

  always #5 clk = ~clk;

  work_dispatcher dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .midstate         (midstate),
    .header_leftovers (header_leftovers),
    .target           (target),
    .solver_rst_n     (solver_rst_n),
    .solver_state     (solver_state),
    .solver_nonce     (solver_nonce),
    .busy             (busy)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Host receive side: 0 always ready, 1 pattern 1-0-0, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1: begin out_ready = (or_idx % 3 == 0); or_idx++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every output handshake pops the scoreboard; stalled bytes must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("out_valid_held", out_valid, 1);
        chk("out_data_stable", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_byte: got %0h expected none", out_data);
        end else begin
          chk("out_byte", out_data, exp_q.pop_front());
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
      if (watch_rst && solver_rst_n) rst_rose = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    logic hs;
    gap = $urandom_range(0, 2);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL in_handshake_timeout: got no in_ready expected handshake for %0h", b);
    end
  endtask

  task automatic send_body(input logic [7:0] flip);
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < 76; k++) begin
      send_byte(pl[k]);
      cs = cs ^ pl[k];
    end
    send_byte(cs ^ flip);
  endtask

  task automatic check_fields();
    logic [255:0] em;
    logic [95:0]  eh;
    logic [255:0] et;
    for (int k = 0; k < 32; k++) em[255-8*k -: 8] = pl[k];
    for (int k = 0; k < 12; k++) eh[95-8*k -: 8] = pl[32+k];
    for (int k = 0; k < 32; k++) et[255-8*k -: 8] = pl[44+k];
    chk("midstate", midstate, em);
    chk("header_leftovers", {160'h0, header_leftovers}, {160'h0, eh});
    chk("target", target, et);
    chk("midstate_first_byte", midstate[255:248], pl[0]);
    chk("target_last_byte", target[7:0], pl[75]);
  endtask

  // Called #1 after the checksum handshake of a good frame.
  task automatic check_start();
    chk("solver_rst_n_check_cycle", solver_rst_n, 0);
    chk("in_ready_check_cycle", in_ready, 0);
    @(posedge clk);
    #1;
    chk("solver_rst_n_run", solver_rst_n, 1);
    chk("busy_run", busy, 1);
    check_fields();
  endtask

  task automatic wait_out_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL report_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
  endtask

  task automatic run_result(input logic [2:0] st, input logic [31:0] nonce, input logic with_sync);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    chk("busy_before_result", busy, 1);
    chk("solver_rst_n_before_result", solver_rst_n, 1);
    solver_state = st;
    solver_nonce = nonce;
    exp_q.push_back(st == 3'd2 ? 8'h01 : 8'h02);
    exp_q.push_back(nonce[31:24]);
    exp_q.push_back(nonce[23:16]);
    exp_q.push_back(nonce[15:8]);
    exp_q.push_back(nonce[7:0]);
    if (with_sync) begin
      in_data  = SYNC;
      in_valid = 1'b1;
    end
    @(negedge clk);
    chk("in_ready_result_wins", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    solver_state = 3'd0;
    solver_nonce = $urandom;
    wait_out_done();
    chk("solver_rst_n_after_report", solver_rst_n, 0);
    chk("busy_after_report", busy, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < 76; k++) pl[k] = 8'($urandom);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    solver_state = 3'd0;
    solver_nonce = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_solver_rst_n", solver_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_midstate", midstate, 0);
    chk("rst_target", target, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame 00..4B, then a found solution.
    for (int k = 0; k < 76; k++) pl[k] = 8'(k);
    send_byte(8'h33);
    send_byte(SYNC);
    send_body(8'h00);
    check_start();
    or_mode = 0;
    run_result(3'd2, 32'h12345678, 1'b0);

    // Bad checksum: single NACK byte, solver never released.
    exp_q.push_back(8'hEE);
    rst_rose  = 1'b0;
    watch_rst = 1'b1;
    send_byte(SYNC);
    send_body(8'h01);
    wait_out_done();
    repeat (3) @(posedge clk);
    #1;
    watch_rst = 1'b0;
    chk("nack_solver_never_released", rst_rose, 0);
    chk("nack_in_ready_idle", in_ready, 1);
    chk("nack_busy", busy, 0);

    // Exhausted with 1-0-0 backpressure; an abort byte coincides with the result.
    rand_payload();
    send_byte(SYNC);
    send_body(8'h00);
    check_start();
    or_mode = 1;
    or_idx  = 0;
    run_result(3'd3, 32'hFFFFFFFF, 1'b1);

    // Abort during RUN, then a new frame restarts the solver.
    or_mode = 2;
    rand_payload();
    send_byte(SYNC);
    send_body(8'h00);
    check_start();
    repeat (3) @(posedge clk);
    #1;
    send_byte(SYNC);
    chk("abort_solver_rst_n", solver_rst_n, 0);
    chk("abort_busy", busy, 0);
    rand_payload();
    send_body(8'h00);
    check_start();
    run_result(3'd2, $urandom, 1'b0);

    // Asynchronous reset in the middle of a frame.
    rand_payload();
    send_byte(SYNC);
    for (int k = 0; k < 40; k++) send_byte(pl[k]);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_solver_rst_n", solver_rst_n, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_midstate", midstate, 0);
    chk("arst_header", {160'h0, header_leftovers}, 0);
    chk("arst_target", target, 0);
    chk("arst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_payload();
    pl[10] = SYNC;
    pl[60] = SYNC;
    send_byte(SYNC);
    send_body(8'h00);
    check_start();
    run_result(3'd3, $urandom, 1'b0);

    // Random jobs with random backpressure.
    for (int j = 0; j < 4; j++) begin
      rand_payload();
      if ($urandom_range(0, 1) == 1) pl[$urandom_range(0, 75)] = SYNC;
      send_byte(SYNC);
      send_body(8'h00);
      check_start();
      run_result(($urandom_range(0, 1) == 1) ? 3'd2 : 3'd3, $urandom, 1'b0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
